spi_cfg_sequencer: RTL
======================

Name: spi_cfg_sequencer

Overview:
Upstream feeder for the 16-bit SPI register writer. It walks a fixed table of NUM_REGS 16-bit configuration words. For each word it presents the word on regdata, issues a one-cycle GO pulse, waits for the writer's ORDY handshake to complete, then waits an inter-frame gap. It is used at power-up or on request to configure an SPI peripheral (codec, ADC, accelerometer) on the DE2-115.

Parameters:
NUM_REGS, 8, number of table entries sent per sequence (1..256)
GAP_CYCLES, 16, idle CLK cycles between the end of one frame and the next GO (>=1)
TIMEOUT_CYCLES, 4096, max CLK cycles spent in one wait state before aborting with error

Ports:
CLK  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to run the full table; ignored unless idle
ORDY  in  1  writer ready level: 1 = idle/accepting, 0 = transfer in progress
regdata  out  16  word to the writer; stable from LOAD until the frame completes
GO  out  1  one-cycle pulse to the writer, registered
busy  out  1  high from the cycle after start until DONE or ERR
done  out  1  one-cycle pulse when the last frame and its gap complete
error  out  1  sticky; set on timeout; cleared by reset or the next accepted start
idx  out  8  index of the current table entry

Behaviour:
- Reset values (synchronous, next edge with reset=1): state=IDLE, regdata=0, GO=0, busy=0, done=0, error=0, idx=0, gap/timeout counters=0. Reset mid-sequence aborts immediately; GO is never asserted in the reset cycle.
- Table: combinational lookup word = table(idx), supplied by a sub-module. Entries at idx >= NUM_REGS return 16'h0000 and are never sent.
- IDLE: on start=1, set idx=0, clear error, busy=1, go to LOAD. start arriving in any other state is ignored.
- LOAD (1 cycle): regdata<=table(idx); timeout counter cleared; go to ISSUE.
- ISSUE: if ORDY=1, assert GO for exactly this one cycle and go to WAIT_ACK. Otherwise stay; the timeout counter increments.
- WAIT_ACK: wait for ORDY=0 (writer accepted the word). Then go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE: wait for ORDY=1. Then go to GAP with gap counter=0.
- GAP: count GAP_CYCLES cycles. When the count is reached: if idx==NUM_REGS-1, go to DONE; else idx<=idx+1 and go to LOAD.
- DONE (1 cycle): done=1, busy=0, idx=0, then IDLE.
- Timeout: in ISSUE, WAIT_ACK or WAIT_DONE, if the counter reaches TIMEOUT_CYCLES-1 without the awaited ORDY level, go to ERR.
- ERR (1 cycle): error=1, busy=0, GO=0, then IDLE. done is not pulsed.
- Latency: GO rises 2 cycles after start when ORDY=1 (LOAD, then ISSUE). Per frame: 2 cycles + writer busy time + GAP_CYCLES.
- regdata changes only in LOAD. GO never asserts twice for the same idx.
- ORDY already low in ISSUE: hold; no GO issued.
- ORDY returns high with no low phase: stays in WAIT_ACK, then times out.
- NUM_REGS=1: a single frame, then DONE.
- start and reset in the same cycle: reset wins.

Decomposition:
- Package spi_cfg_pkg: state encoding constants (IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, GAP, DONE, ERR; 3-bit), width constants (DATA_W=16, IDX_W=8), default table words.
- Sub-module spi_cfg_rom: purely combinational idx -> 16-bit word, a case statement with default 16'h0000. The sequencer instantiates it once.

Test Plan:
- Basic run: NUM_REGS=3, GAP_CYCLES=4, behavioural writer holds ORDY low for 20 cycles after GO -> exactly 3 GO pulses; regdata = table(0), table(1), table(2) at the respective GOs; done pulses once; busy low afterwards; error=0.
- Back-pressure: ORDY=0 for 50 cycles before start, then 1 -> GO delayed until the first cycle ORDY=1; no GO while ORDY=0.
- Timeout: TIMEOUT_CYCLES=64, writer never drops ORDY after GO -> error=1 at most 65 cycles after GO; busy=0; no done; next start clears error and restarts at idx=0.
- Reset mid-sequence: assert reset during WAIT_DONE of idx=1 -> next cycle all outputs at reset values; no further GO until a new start.
- Start ignored while busy: pulse start during GAP of idx=0 -> sequence continues unchanged; total GO count = NUM_REGS.
- Gap check: GAP_CYCLES=16 -> ORDY rise to next GO = exactly 18 cycles (16 gap + LOAD + ISSUE).

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration sequencer.
// The default table initialises a WM8731-style codec over the 16-bit writer.
package spi_cfg_pkg;

    localparam int DATA_W      = 16;
    localparam int IDX_W       = 8;
    localparam int TABLE_DEPTH = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_GAP       = 3'd5,
        S_DONE      = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    // Word layout: [15:9] register address, [8:0] register value.
    localparam logic [DATA_W-1:0] DEFAULT_TABLE [TABLE_DEPTH] = '{
        16'h1E00,
        16'h0C10,
        16'h0812,
        16'h0A00,
        16'h0E42,
        16'h1000,
        16'h1201,
        16'h0017,
        16'h0217,
        16'h0479,
        16'h0679,
        16'h0C00,
        16'h0A06,
        16'h0813,
        16'h0E4A,
        16'h1023
    };

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_cfg_rom.sv
// Combinational configuration table: index in, 16-bit word out.
// Indices at or beyond NUM_REGS read as zero so unused slots are inert.
module spi_cfg_rom
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic [IDX_W-1:0]  i_idx,
    output logic [DATA_W-1:0] o_word
);

    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] w_word;
    logic              w_in_range;

    always_comb begin
        w_word = '0;
        case (i_idx)
            8'd0:    w_word = DEFAULT_TABLE[0];
            8'd1:    w_word = DEFAULT_TABLE[1];
            8'd2:    w_word = DEFAULT_TABLE[2];
            8'd3:    w_word = DEFAULT_TABLE[3];
            8'd4:    w_word = DEFAULT_TABLE[4];
            8'd5:    w_word = DEFAULT_TABLE[5];
            8'd6:    w_word = DEFAULT_TABLE[6];
            8'd7:    w_word = DEFAULT_TABLE[7];
            8'd8:    w_word = DEFAULT_TABLE[8];
            8'd9:    w_word = DEFAULT_TABLE[9];
            8'd10:   w_word = DEFAULT_TABLE[10];
            8'd11:   w_word = DEFAULT_TABLE[11];
            8'd12:   w_word = DEFAULT_TABLE[12];
            8'd13:   w_word = DEFAULT_TABLE[13];
            8'd14:   w_word = DEFAULT_TABLE[14];
            8'd15:   w_word = DEFAULT_TABLE[15];
            default: w_word = 16'h0000;
        endcase
    end

    assign w_in_range = ({1'b0, i_idx} < IDX_LIMIT);
    assign o_word     = w_in_range ? w_word : '0;

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Walks the configuration table and hands each word to the SPI register writer
// with a GO/ORDY handshake, an inter-frame gap and a per-wait timeout.
//
// IDLE      | waiting for start
// LOAD      | latch table word onto regdata
// ISSUE     | wait for ORDY high, then pulse GO
// WAIT_ACK  | wait for writer to drop ORDY
// WAIT_DONE | wait for writer to raise ORDY
// GAP       | idle spacing before next frame
// DONE      | one-cycle done pulse
// ERR       | one-cycle abort after timeout
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REGS       = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              ORDY,
    output logic [DATA_W-1:0] regdata,
    output logic              GO,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  idx
);

    localparam int GAP_W = clog2_min1(GAP_CYCLES);
    localparam int TMO_W = clog2_min1(TIMEOUT_CYCLES);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_regdata;
    logic              r_go;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [IDX_W-1:0]  r_idx;
    logic [GAP_W-1:0]  r_gap;
    logic [TMO_W-1:0]  r_tmo;

    logic [DATA_W-1:0] w_word;
    logic              w_level_ok;

    spi_cfg_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .i_idx  (r_idx),
        .o_word (w_word)
    );

    // The ORDY level each wait state is looking for.
    always_comb begin
        w_level_ok = 1'b0;
        case (r_state)
            S_ISSUE:     w_level_ok = ORDY;
            S_WAIT_ACK:  w_level_ok = ~ORDY;
            S_WAIT_DONE: w_level_ok = ORDY;
            default:     w_level_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_regdata <= '0;
            r_go      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_idx     <= '0;
            r_gap     <= '0;
            r_tmo     <= '0;
        end else begin
            r_go   <= 1'b0;
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_regdata <= w_word;
                    r_tmo     <= '0;
                    r_state   <= S_ISSUE;
                end

                S_ISSUE, S_WAIT_ACK, S_WAIT_DONE: begin
                    if (w_level_ok) begin
                        r_tmo <= '0;
                        case (r_state)
                            S_ISSUE: begin
                                r_go    <= 1'b1;
                                r_state <= S_WAIT_ACK;
                            end
                            S_WAIT_ACK: begin
                                r_state <= S_WAIT_DONE;
                            end
                            default: begin
                                r_gap   <= '0;
                                r_state <= S_GAP;
                            end
                        endcase
                    end else if (r_tmo == TMO_LAST) begin
                        // Error and busy change on entry so they are visible during ERR.
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        if (r_idx == IDX_LAST) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_idx   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                S_ERR: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign regdata = r_regdata;
    assign GO      = r_go;
    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = r_error;
    assign idx     = r_idx;

endmodule
